// File: rtl/cla_pkg.sv
// Shared adder types for the CLA datapath and its clients.
// Pure type/constant package: no logic, no latency, no flow control.
package cla_pkg;
  localparam int CLA_W = 32;

  typedef logic [CLA_W-1:0] cla_word_t;

  typedef struct packed {
    cla_word_t sum;
    logic      cout;
    logic      of;
  } cla_res_t;
endpackage

// File: rtl/CLA.sv
// 32-bit carry-lookahead adder, no carry-in, with carry-out and signed overflow.
// Purely combinational: zero latency, no handshake.
module CLA
  import cla_pkg::*;
(
  input  cla_word_t in1,
  input  cla_word_t in2,
  output cla_word_t sum,
  output logic      cout,
  output logic      of
);
  cla_word_t        p;
  cla_word_t        g;
  logic [CLA_W:0]   c;

  assign p = in1 ^ in2;
  assign g = in1 & in2;

  // 4-bit lookahead groups; each group's carry-out is formed from group G/P.
  always_comb begin
    c = '0;
    for (int k = 0; k < CLA_W; k += 4) begin
      c[k+1] = g[k] | (p[k] & c[k]);
      c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
             | (p[k+2] & p[k+1] & p[k] & c[k]);
      c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
             | (p[k+3] & p[k+2] & p[k+1] & g[k]) | ((&p[k +: 4]) & c[k]);
    end
  end

  assign sum  = p ^ c[CLA_W-1:0];
  assign cout = c[CLA_W];
  assign of   = (in1[CLA_W-1] == in2[CLA_W-1]) & (sum[CLA_W-1] != in1[CLA_W-1]);
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or above the pointer.
// Grant is combinational; pointer moves past the winner only when advance is high.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);
  logic [IDX_W-1:0] ptr;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(ptr) + off) % N) == i)) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/cla_rr_scheduler.sv
// Shares one CLA among N_REQ requesters with round-robin grant and a one-deep result register.
// Result appears one cycle after issue; a stalled result blocks all grants until drained.
module cla_rr_scheduler
  import cla_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_sum,
  output logic                     res_cout,
  output logic                     res_of,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [CNT_W-1:0]         ops_done
);
  localparam int ID_W = $clog2(N_REQ);

  logic             can_issue;
  logic             issue;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  cla_word_t        op_a;
  cla_word_t        op_b;
  cla_word_t        cla_sum;
  logic             cla_cout;
  logic             cla_of;
  cla_res_t         res_q;

  assign can_issue = !res_valid || res_ready;
  assign arb_req   = (can_issue && !rst) ? req_valid : '0;

  rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (issue),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign issue     = |gnt;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        op_a = req_a[i*W +: W];
        op_b = req_b[i*W +: W];
      end
    end
  end

  CLA u_cla (
    .in1  (op_a),
    .in2  (op_b),
    .sum  (cla_sum),
    .cout (cla_cout),
    .of   (cla_of)
  );

  // Data registers only load on issue, so a drain-only cycle leaves stale data behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_q     <= '0;
      res_id    <= '0;
      ops_done  <= '0;
    end else begin
      if (issue) begin
        res_valid <= 1'b1;
        res_q     <= '{sum: cla_sum, cout: cla_cout, of: cla_of};
        res_id    <= gnt_idx;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      if (res_valid && res_ready) begin
        ops_done <= ops_done + 1'b1;
      end
    end
  end

  assign res_sum  = res_q.sum;
  assign res_cout = res_q.cout;
  assign res_of   = res_q.of;

  for (genvar i = 0; i < N_REQ; i++) begin : g_hold
    a_operand_hold: assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i]) |=>
        (!req_valid[i] || ($stable(req_a[i*W +: W]) && $stable(req_b[i*W +: W]))));
  end
endmodule
